// File: rtl/multi_alarm.sv
// Multi-slot alarm controller: keypad digit entry with range checking, per-minute
// matching against the running clock, and an LED blink sequence with stop and snooze.
module multi_alarm #(
  parameter int NUM_ALARMS  = 4,
  parameter int SEL_W       = 2,
  parameter int LED_W       = 8,
  parameter int BLINK_HALF  = 500,
  parameter int BLINK_COUNT = 10,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            keypad,
  input  logic                  alarm_set_mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  alarm_clear,
  input  logic                  stop,
  input  logic                  snooze,
  input  logic                  minute_tick,
  input  logic [3:0]            cur_h_ten,
  input  logic [3:0]            cur_h_one,
  input  logic [3:0]            cur_m_ten,
  input  logic [3:0]            cur_m_one,
  output logic [3:0]            alarm_h_ten,
  output logic [3:0]            alarm_h_one,
  output logic [3:0]            alarm_m_ten,
  output logic [3:0]            alarm_m_one,
  output logic [1:0]            entry_cnt,
  output logic                  alarm_set_done,
  output logic                  entry_error,
  output logic [NUM_ALARMS-1:0] alarm_enable,
  output logic                  ringing,
  output logic                  snoozing,
  output logic [SEL_W-1:0]      ring_slot,
  output logic [LED_W-1:0]      leds
);

  localparam int HALF_W = $clog2(BLINK_HALF + 1);
  localparam int PER_W  = $clog2(BLINK_COUNT + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_MIN + 1);

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(BLINK_COUNT - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_MIN - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RING_ON  = 2'd1;
  localparam logic [1:0] RING_OFF = 2'd2;
  localparam logic [1:0] SNOOZE   = 2'd3;

  function automatic logic [3:0] key_digit(input logic [9:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

  // Position-dependent range check; the hour-units limit depends on the stored tens digit.
  function automatic logic digit_valid(input logic [1:0] pos, input logic [3:0] d,
                                       input logic [3:0] h_ten);
    logic ok;
    case (pos)
      2'd0:    ok = (d <= 4'd2);
      2'd1:    ok = (h_ten == 4'd2) ? (d <= 4'd3) : (d <= 4'd9);
      2'd2:    ok = (d <= 4'd5);
      default: ok = (d <= 4'd9);
    endcase
    return ok;
  endfunction

  logic [9:0]       keypad_prev;
  logic             key_onehot;
  logic             key_event;
  logic [3:0]       digit;
  logic             digit_ok;

  logic [SEL_W-1:0] edit_slot;
  logic [3:0]       sh_h_ten;
  logic [3:0]       sh_h_one;
  logic [3:0]       sh_m_ten;

  logic [3:0]       slot_h_ten [NUM_ALARMS];
  logic [3:0]       slot_h_one [NUM_ALARMS];
  logic [3:0]       slot_m_ten [NUM_ALARMS];
  logic [3:0]       slot_m_one [NUM_ALARMS];

  logic [1:0]        state;
  logic [HALF_W-1:0] half_cnt;
  logic [PER_W-1:0]  period_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic              match_found;
  logic [SEL_W-1:0]  match_idx;
  logic              active;

  assign key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
  assign key_event  = key_onehot && (keypad_prev == 10'd0);
  assign digit      = key_digit(keypad);
  assign digit_ok   = digit_valid(entry_cnt, digit, sh_h_ten);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keypad_prev <= '0;
    end else begin
      keypad_prev <= keypad;
    end
  end

  // Entry: digits accumulate in shadow registers and reach the slot only on the 4th digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_cnt      <= 2'd0;
      alarm_set_done <= 1'b0;
      entry_error    <= 1'b0;
      edit_slot      <= '0;
      sh_h_ten       <= 4'd0;
      sh_h_one       <= 4'd0;
      sh_m_ten       <= 4'd0;
      alarm_enable   <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_h_ten[i] <= 4'd0;
        slot_h_one[i] <= 4'd0;
        slot_m_ten[i] <= 4'd0;
        slot_m_one[i] <= 4'd0;
      end
    end else begin
      alarm_set_done <= 1'b0;
      entry_error    <= 1'b0;
      if (!alarm_set_mode) begin
        entry_cnt <= 2'd0;
      end else if (key_event) begin
        if (!digit_ok) begin
          entry_error <= 1'b1;
          entry_cnt   <= 2'd0;
        end else begin
          case (entry_cnt)
            2'd0: begin
              edit_slot <= sel;
              sh_h_ten  <= digit;
              entry_cnt <= 2'd1;
            end
            2'd1: begin
              sh_h_one  <= digit;
              entry_cnt <= 2'd2;
            end
            2'd2: begin
              sh_m_ten  <= digit;
              entry_cnt <= 2'd3;
            end
            default: begin
              if (int'(edit_slot) < NUM_ALARMS) begin
                slot_h_ten[edit_slot]   <= sh_h_ten;
                slot_h_one[edit_slot]   <= sh_h_one;
                slot_m_ten[edit_slot]   <= sh_m_ten;
                slot_m_one[edit_slot]   <= digit;
                alarm_enable[edit_slot] <= 1'b1;
              end
              alarm_set_done <= 1'b1;
              entry_cnt      <= 2'd0;
            end
          endcase
        end
      end
      if (alarm_clear && (int'(sel) < NUM_ALARMS)) begin
        alarm_enable[sel] <= 1'b0;
      end
    end
  end

  always_comb begin
    alarm_h_ten = 4'd0;
    alarm_h_one = 4'd0;
    alarm_m_ten = 4'd0;
    alarm_m_one = 4'd0;
    if (int'(sel) < NUM_ALARMS) begin
      alarm_h_ten = slot_h_ten[sel];
      alarm_h_one = slot_h_one[sel];
      alarm_m_ten = slot_m_ten[sel];
      alarm_m_one = slot_m_one[sel];
    end
  end

  // Scan downwards so the lowest-index matching slot is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_enable[i] && slot_h_ten[i] == cur_h_ten && slot_h_one[i] == cur_h_one &&
          slot_m_ten[i] == cur_m_ten && slot_m_one[i] == cur_m_one) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
      end
    end
  end

  assign active = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ring_slot  <= '0;
      half_cnt   <= '0;
      period_cnt <= '0;
      snz_cnt    <= '0;
    end else if (active && alarm_clear && (sel == ring_slot)) begin
      state <= IDLE;
    end else if (active && stop) begin
      state <= IDLE;
    end else if ((state == RING_ON || state == RING_OFF) && snooze) begin
      state    <= SNOOZE;
      snz_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (minute_tick && !alarm_set_mode && match_found) begin
            state      <= RING_ON;
            ring_slot  <= match_idx;
            half_cnt   <= '0;
            period_cnt <= '0;
          end
        end
        RING_ON: begin
          if (half_cnt == HALF_LAST) begin
            state    <= RING_OFF;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        RING_OFF: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (period_cnt == PER_LAST) begin
              state      <= IDLE;
              period_cnt <= '0;
            end else begin
              state      <= RING_ON;
              period_cnt <= period_cnt + 1'b1;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SNOOZE: begin
          if (minute_tick) begin
            if (snz_cnt == SNZ_LAST) begin
              state      <= RING_ON;
              snz_cnt    <= '0;
              half_cnt   <= '0;
              period_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ringing  = (state == RING_ON) || (state == RING_OFF);
  assign snoozing = (state == SNOOZE);
  assign leds     = (state == RING_ON) ? {LED_W{1'b1}} : {LED_W{1'b0}};

endmodule

// File: doc/multi_alarm.md
Name: multi_alarm

Overview:
- Parametrised successor to the single-alarm block. Holds NUM_ALARMS independent alarm slots, each entered digit by digit from the one-hot keypad with range validation.
- Compares enabled slots against the running clock on every minute boundary. Drives a parametrised LED blink sequence with stop and snooze.
- Sits between the keypad decoder, the timekeeping counter and the LED/7-segment drivers.

Parameters:
NUM_ALARMS, 4, number of alarm slots (2..8)
SEL_W, 2, width of slot select; must equal clog2(NUM_ALARMS)
LED_W, 8, LED bus width
BLINK_HALF, 500, clk cycles per LED on-phase and per off-phase (500 = 0.5 s at 1 kHz)
BLINK_COUNT, 10, number of on/off periods per ring
SNOOZE_MIN, 5, minute_tick pulses before a snoozed alarm re-rings (1..15)

Ports:
clk  in  1  1 kHz system clock
rst  in  1  asynchronous, active-low reset
keypad  in  10  one-hot digit keys 0..9, level while held
alarm_set_mode  in  1  entry mode enable
sel  in  SEL_W  slot being edited/displayed
alarm_clear  in  1  one-cycle pulse: disable slot sel
stop  in  1  one-cycle pulse: silence ring/snooze
snooze  in  1  one-cycle pulse: snooze current ring
minute_tick  in  1  one-cycle pulse when the clock minute changes
cur_h_ten, cur_h_one, cur_m_ten, cur_m_one  in  4 each  current time BCD (valid on minute_tick)
alarm_h_ten, alarm_h_one, alarm_m_ten, alarm_m_one  out  4 each  stored time of slot sel
entry_cnt  out  2  digits accepted in current entry
alarm_set_done  out  1  one-cycle pulse on successful commit
entry_error  out  1  one-cycle pulse on rejected digit
alarm_enable  out  NUM_ALARMS  per-slot armed flags
ringing  out  1  high in RING_ON/RING_OFF
snoozing  out  1  high in SNOOZE
ring_slot  out  SEL_W  slot ringing/snoozed
leds  out  LED_W  blink output

Behaviour:
- Reset (rst=0, async): all slot times 0:00, alarm_enable=0, entry_cnt=0, pulses 0, FSM IDLE, ringing=0, snoozing=0, ring_slot=0, leds=0, keypad_prev=0.
- Key event: keypad is exactly one-hot while keypad_prev==0 (registered every cycle). Multi-hot or zero keypad is ignored with no error.
- Entry runs only while alarm_set_mode=1. sel is latched into the edit slot on the digit with entry_cnt=0. Digits go to shadow registers; stored slots are untouched until commit.
- Digit limits:
  - h_ten ≤2.
  - h_one ≤9, or ≤3 if h_ten=2.
  - m_ten ≤5.
  - m_one ≤9.
- Out-of-range digit: entry_error pulses next cycle, entry_cnt→0, shadow discarded.
- 4th valid digit: shadow copied to the latched slot, its enable bit set, alarm_set_done pulses, entry_cnt→0. All of these take effect the cycle after the key event.
- alarm_set_mode falling mid-entry: shadow discarded, entry_cnt→0, no pulse.
- alarm_clear clears alarm_enable[sel]; times are retained. Clearing the slot in ring_slot while ringing or snoozing forces IDLE and leds=0 next cycle.
- Alarm outputs are combinational muxes of stored slot[sel].
- Match: on minute_tick with FSM IDLE, alarm_set_mode=0, and slot enabled with time == cur time. The lowest-index matching slot wins.
- Matches while not IDLE, or in set mode, are dropped (not queued).
- FSM states and transitions:
  - IDLE: on match → RING_ON, ring_slot=slot. ringing=1 and leds all-ones the next cycle.
  - RING_ON: leds all-ones for BLINK_HALF cycles → RING_OFF.
  - RING_OFF: leds=0 for BLINK_HALF cycles. Period counter increments; if it reaches BLINK_COUNT → IDLE, else → RING_ON.
  - SNOOZE: leds=0; counts minute_ticks; on SNOOZE_MIN-th tick → RING_ON with period counter 0, ringing next cycle.
- Priority, highest first: reset > alarm_clear of ring_slot > stop > snooze > timers.
- stop in any non-IDLE state → IDLE, leds=0.
- snooze in RING_ON/RING_OFF → SNOOZE, snooze counter 0. snooze in SNOOZE or IDLE is ignored.
- Slot remains enabled after ringing, so it re-arms daily.
- Counter widths are sized by parameter. No counter wraps silently.

Test Plan:
- Set mode, sel=1, keys 0,7,3,0 (each released) → alarm_set_done one pulse after 4th key; slot1=07:30; alarm_enable=4'b0010; entry_cnt back to 0.
- Keys 2,4 → entry_error pulse after "4", entry_cnt=0, slot unchanged. Keys 1,6 then drop set mode → no pulse, slot unchanged. Held key and two-key press → only one digit accepted.
- Slot1=07:30 enabled, cur=07:30, minute_tick → ringing=1, leds=8'hFF next cycle, ring_slot=1. With BLINK_HALF=4, BLINK_COUNT=2 → FF for 4, 00 for 4, FF for 4, 00 for 4, then IDLE.
- Slots 0 and 2 both 06:00 enabled, tick at 06:00 → ring_slot=0. A second match tick while ringing → ignored.
- SNOOZE_MIN=2: snooze during RING_ON → snoozing=1, leds=0. First tick: no ring. Second tick: ringing=1 next cycle. stop during SNOOZE → IDLE.
- alarm_clear with sel=ring_slot during RING_ON → IDLE, leds=0, enable bit cleared. rst low mid-ring → all outputs to reset values immediately.
